// File: rtl/pipe_pkg.sv
// Shared constants for the pipe_stage_reg slice: state encodings and reset payload.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_pkg;

    // Stage occupancy states. SKID is only reachable when PIPE_STAGE_SKID_EN is defined.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    // RISC-V canonical NOP (addi x0, x0, 0), used as the payload after reset or flush.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // A handshake fires when both sides agree on the same edge.
    function automatic logic hs_fire(input logic vld, input logic rdy);
        return vld & rdy;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// Storage slot: WIDTH-bit load-enabled payload register plus valid bit.
// Latency: 1 cycle from i_load to o_data/o_valid.
// Backpressure: none inside the slot; the parent decides when to load or drop.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   FLUSH_VAL = WIDTH'(NOP_INSTR)
) (
    input  logic             clk,
    input  logic             i_clr_n,
    input  logic             i_load,
    input  logic             i_drop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Clear wins over load, load wins over drop; a drop keeps the payload so the
    // output holds its last value while invalid.
    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_data  <= FLUSH_VAL;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_drop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush; optional skid slot under macro PIPE_STAGE_SKID_EN.
// Latency: 1 cycle from input transfer in EMPTY to out_valid/out_data.
// Backpressure: default build in_ready = !out_valid || out_ready; skid build in_ready is registered (state != SKID).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   FLUSH_VAL = WIDTH'(NOP_INSTR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_clr_n;
    logic             w_main_load;
    logic             w_main_drop;
    logic [WIDTH-1:0] w_main_din;
    logic             w_main_vld;

    // Reset and flush both wipe the slots; reset additionally holds in_ready low.
    assign w_clr_n    = rst & ~flush;
    assign w_in_xfer  = hs_fire(in_valid, in_ready);
    assign w_out_xfer = hs_fire(out_valid, out_ready);
    assign out_valid  = w_main_vld;

`ifdef PIPE_STAGE_SKID_EN
    logic             w_skid_load;
    logic             w_skid_drop;
    logic [WIDTH-1:0] w_skid_dat;
    logic             w_skid_vld;
    logic             r_in_rdy;

    // Next-state and slot control: the skid slot absorbs the beat that arrives
    // while the main slot is stalled, so in_ready can lag by one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_main_load = 1'b0;
        w_main_drop = 1'b0;
        w_main_din  = in_data;
        w_skid_load = 1'b0;
        w_skid_drop = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_main_load = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_load = 1'b1;
                end else if (w_out_xfer) begin
                    w_main_drop = 1'b1;
                    w_state_nxt = ST_EMPTY;
                end else if (w_in_xfer) begin
                    w_skid_load = 1'b1;
                    w_state_nxt = ST_SKID;
                end
            end
            ST_SKID: begin
                // in_ready is low here, so only the output side can move.
                if (w_out_xfer && w_skid_vld) begin
                    w_main_load = 1'b1;
                    w_main_din  = w_skid_dat;
                    w_skid_drop = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // in_ready comes straight from a flop so it has no path from out_ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_in_rdy <= 1'b0;
        end else if (flush) begin
            r_in_rdy <= 1'b1;
        end else begin
            r_in_rdy <= (w_state_nxt != ST_SKID);
        end
    end

    assign in_ready = r_in_rdy;

    pipe_slot #(
        .WIDTH     (WIDTH),
        .FLUSH_VAL (FLUSH_VAL)
    ) u_skid_slot (
        .clk     (clk),
        .i_clr_n (w_clr_n),
        .i_load  (w_skid_load),
        .i_drop  (w_skid_drop),
        .i_data  (in_data),
        .o_data  (w_skid_dat),
        .o_valid (w_skid_vld)
    );
`else
    // Next-state and slot control for the single-slot stage; an input transfer
    // in FULL can only happen together with an output transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_main_load = 1'b0;
        w_main_drop = 1'b0;
        w_main_din  = in_data;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_main_load = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_in_xfer) begin
                    w_main_load = 1'b1;
                end else if (w_out_xfer) begin
                    w_main_drop = 1'b1;
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Ready when the slot is free or being drained this cycle; never during reset.
    assign in_ready = rst & (~w_main_vld | out_ready);
`endif

    // State register: reset outranks flush, flush outranks any transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    pipe_slot #(
        .WIDTH     (WIDTH),
        .FLUSH_VAL (FLUSH_VAL)
    ) u_main_slot (
        .clk     (clk),
        .i_clr_n (w_clr_n),
        .i_load  (w_main_load),
        .i_drop  (w_main_drop),
        .i_data  (w_main_din),
        .o_data  (out_data),
        .o_valid (w_main_vld)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based reference model.
// Latency: one check set per clock, sampled 1 time unit after the falling edge.
// Backpressure: out_ready driven by directed steps and then randomly.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    pipe_stage_reg #(
        .WIDTH     (32),
        .FLUSH_VAL (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: beats held by the stage, oldest first.
    logic [31:0] q[$];
    logic [31:0] shown;
    bit          rdy_reg;
    bit          last_acc;
    int          checks;
    int          passes;
    int          n_out_dut;
    int          n_out_mdl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic v, input logic [31:0] d, input logic ordy,
                         input logic fl, input logic rs);
        logic exp_rdy;
        logic in_x;
        logic out_x;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        #1;
        if (SKID) exp_rdy = rdy_reg;
        else      exp_rdy = rs && (q.size() == 0 || ordy);
        chk("in_ready",  32'(in_ready),  32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out_data",  out_data,       shown);
        in_x  = v && exp_rdy;
        out_x = (q.size() != 0) && ordy;
        if (out_valid === 1'b1 && out_ready === 1'b1) n_out_dut++;
        if (out_x) n_out_mdl++;
        last_acc = in_x && rs && !fl;
        if (!rs) begin
            q.delete();
            shown   = NOP;
            rdy_reg = 1'b0;
        end else if (fl) begin
            q.delete();
            shown   = NOP;
            rdy_reg = 1'b1;
        end else begin
            if (out_x) void'(q.pop_front());
            if (in_x)  q.push_back(d);
            if (q.size() != 0) shown = q[0];
            rdy_reg = (q.size() < 2);
        end
        @(posedge clk);
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        n_out_dut = 0;
        n_out_mdl = 0;
        last_acc  = 1'b0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        shown   = NOP;
        rdy_reg = 1'b0;

        // Reset state, then release with one idle cycle.
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Single beat: one-cycle latency.
        cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0,         1'b1, 1'b0, 1'b1);

        // Back-to-back stream with downstream always ready.
        cycle(1'b1, 32'h1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h2, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h3, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Stall downstream while offering A, B, C; then release and drain.
        cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b1);
        if (!last_acc) cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
        last_acc = 1'b0;
        for (int i = 0; i < 6 && !last_acc; i++) cycle(1'b1, 32'hC, 1'b1, 1'b0, 1'b1);
        chk("c_accepted", 32'(last_acc), 32'd1);
        repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Flush in FULL with a same-edge incoming beat: both discarded.
        cycle(1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h66, 1'b0, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Reset with the stage fully occupied; nothing stale may come out.
        cycle(1'b1, 32'h77, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h88, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0,  1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
                  ($urandom % 97) == 0, ($urandom % 211) != 0);
        end

        // Drain and compare beat counts.
        repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("out_count", n_out_dut, n_out_mdl);
        chk("drained",   32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the payload width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter FLUSH_VAL, default 32'h00000013 (RISC-V NOP), giving the out_data value after reset or flush.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous discard of all held and incoming beats.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream beat is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the stage can accept a beat.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid beat.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the registered payload.

Function
REQ-012 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-013 The block SHALL use states EMPTY (no beat), FULL (main slot valid) and SKID (main and skid slots valid; present only with PIPE_STAGE_SKID_EN).
REQ-014 Transitions: EMPTY->FULL on input transfer; FULL->EMPTY on output transfer without input transfer; FULL->FULL on simultaneous transfers; FULL->SKID on input transfer without output transfer; SKID->FULL on output transfer (skid beat moves to main).
REQ-015 Latency SHALL be 1 cycle: a beat accepted in EMPTY appears on out_data with out_valid=1 in the next cycle.
REQ-016 Beats SHALL leave in acceptance order, with no loss and no duplication.
REQ-017 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-018 While out_valid=0, out_data SHALL hold its last value.
REQ-019 flush=1 SHALL, on that edge, force state EMPTY, out_valid=0 and out_data=FLUSH_VAL, and SHALL discard any beat transferred on the same edge; flush SHALL take priority over all transfers.
REQ-020 rst=0 SHALL take priority over flush.
REQ-021 in_ready SHALL NOT depend combinationally on in_valid.

Reset
REQ-022 While rst=0 at an edge, the block SHALL set state EMPTY, out_valid=0, out_data=FLUSH_VAL and clear the skid slot.
REQ-023 in_ready SHALL be 0 while rst=0; after the first edge with rst=1, in_ready SHALL be 1 in EMPTY.
REQ-024 Deasserting rst mid-stream SHALL discard all beats held before or during reset.

Configuration
REQ-025 With macro PIPE_STAGE_SKID_EN defined, in_ready SHALL be a registered signal equal to (state != SKID) and SHALL have no combinational path from out_ready.
REQ-026 Without PIPE_STAGE_SKID_EN, the skid slot and SKID state SHALL be omitted, and in_ready SHALL be the combinational value (!out_valid || out_ready) when rst=1.

Structure
REQ-027 State encodings (EMPTY/FULL/SKID) and the default NOP constant SHALL live in a shared package pipe_pkg.
REQ-028 Each storage slot SHALL be an instance of sub-module pipe_slot (WIDTH-bit load-enabled register with valid bit, synchronous active-low clear to FLUSH_VAL).

Verification
REQ-029 Reset then in_valid=1, in_data=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF; after reset only: out_data=0x00000013, out_valid=0.
REQ-030 Stream 0x1,0x2,0x3 back-to-back with out_ready=1 -> outputs 0x1,0x2,0x3 on consecutive cycles, in_ready constantly 1.
REQ-031 (SKID_EN) Hold out_ready=0, offer 0xA,0xB,0xC -> 0xA,0xB accepted, in_ready=0 the cycle after 0xB; then out_ready=1 -> 0xA, 0xB, then 0xC in order, with no loss.
REQ-032 State FULL with 0x55, flush=1 and in_valid=1 with 0x66 on the same edge -> next cycle out_valid=0, out_data=0x00000013, and 0x66 never appears.
REQ-033 rst=0 asserted in state SKID -> next cycle out_valid=0 and in_ready=0; after release, in_ready=1 and no stale beat is emitted.
REQ-034 Random in_valid/out_ready for 10k cycles against a scoreboard queue -> order and count match, and out_data is stable under stall.
